// File: rtl/elementwise_wb_agen_if.sv
// Beat stream in from the ElementWise core and addressed beat stream out to the AXI write master.
interface elementwise_wb_agen_if #(
   parameter int unsigned DAT_W  = 256,
   parameter int unsigned ADDR_W = 32
);
   logic              s_valid;
   logic              s_ready;
   logic [DAT_W-1:0]  s_data;
   logic              m_valid;
   logic              m_ready;
   logic [ADDR_W-1:0] m_addr;
   logic [DAT_W-1:0]  m_data;
   logic              m_last;

   // master: the address generator; slave: the surrounding core and write master
   modport master (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_addr, m_data, m_last
   );
   modport slave (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_addr, m_data, m_last
   );
endinterface

// File: rtl/elementwise_wb_agen.sv
// ElementWise write-back: tags each result beat with its CHout_div_Tout/H/W feature-map address
// and holds it in a single output register for the AXI write master.
module elementwise_wb_agen #(
   parameter int unsigned DAT_W     = 256,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned PIX_BYTES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_hout,
   input  logic [CNT_W-1:0]  cfg_wout,
   input  logic [CNT_W-1:0]  cfg_ch_div_tout,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [ADDR_W-1:0] cfg_surface_stride,
   input  logic [ADDR_W-1:0] cfg_line_stride,
   output logic              busy,
   output logic              done,
   elementwise_wb_agen_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  h_q, w_q, c_q;
   logic [ADDR_W-1:0] surf_stride_q, line_stride_q;
   logic [CNT_W-1:0]  w_cnt, h_cnt, c_cnt;
   logic [ADDR_W-1:0] surf_ptr, line_ptr, pix_ptr;
   logic              all_accepted;
   logic              valid_q, last_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DAT_W-1:0]  data_q;

   logic acc, w_end, h_end, c_end, dims_ok;

   assign acc     = bus.s_valid && bus.s_ready;
   assign w_end   = (w_cnt == w_q - CNT_W'(1));
   assign h_end   = (h_cnt == h_q - CNT_W'(1));
   assign c_end   = (c_cnt == c_q - CNT_W'(1));
   assign dims_ok = (cfg_hout != '0) && (cfg_wout != '0) && (cfg_ch_div_tout != '0);

   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign bus.s_ready = (state == RUN) && !all_accepted && (!valid_q || bus.m_ready);
   assign bus.m_valid = valid_q;
   assign bus.m_addr  = addr_q;
   assign bus.m_data  = data_q;
   assign bus.m_last  = last_q;

   // Job control, loop counters and incremental pointers (no multipliers).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         h_q           <= '0;
         w_q           <= '0;
         c_q           <= '0;
         surf_stride_q <= '0;
         line_stride_q <= '0;
         w_cnt         <= '0;
         h_cnt         <= '0;
         c_cnt         <= '0;
         surf_ptr      <= '0;
         line_ptr      <= '0;
         pix_ptr       <= '0;
         all_accepted  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  h_q           <= cfg_hout;
                  w_q           <= cfg_wout;
                  c_q           <= cfg_ch_div_tout;
                  surf_stride_q <= cfg_surface_stride;
                  line_stride_q <= cfg_line_stride;
                  w_cnt         <= '0;
                  h_cnt         <= '0;
                  c_cnt         <= '0;
                  surf_ptr      <= cfg_base_addr;
                  line_ptr      <= cfg_base_addr;
                  pix_ptr       <= cfg_base_addr;
                  all_accepted  <= 1'b0;
                  state         <= dims_ok ? RUN : DONE;
               end
            end
            RUN: begin
               if (acc) begin
                  if (w_end && h_end && c_end) all_accepted <= 1'b1;
                  if (w_end) begin
                     w_cnt <= '0;
                     if (h_end) begin
                        h_cnt    <= '0;
                        c_cnt    <= c_cnt + CNT_W'(1);
                        surf_ptr <= surf_ptr + surf_stride_q;
                        line_ptr <= surf_ptr + surf_stride_q;
                        pix_ptr  <= surf_ptr + surf_stride_q;
                     end else begin
                        h_cnt    <= h_cnt + CNT_W'(1);
                        line_ptr <= line_ptr + line_stride_q;
                        pix_ptr  <= line_ptr + line_stride_q;
                     end
                  end else begin
                     w_cnt   <= w_cnt + CNT_W'(1);
                     pix_ptr <= pix_ptr + ADDR_W'(PIX_BYTES);
                  end
               end
               if (valid_q && bus.m_ready && last_q) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: reload on accept (also covers same-cycle drain), else drain on m_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (acc) begin
         valid_q <= 1'b1;
         last_q  <= w_end && h_end && c_end;
         addr_q  <= pix_ptr;
         data_q  <= bus.s_data;
      end else if (bus.m_ready) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_elementwise_wb_agen.sv
// Directed bench for elementwise_wb_agen: address sequence, handshake timing, backpressure,
// bubbles, zero-dim job, ignored restart and mid-job reset.
module tb_elementwise_wb_agen;
   localparam int unsigned DAT_W  = 256;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  cfg_hout, cfg_wout, cfg_ch_div_tout;
   logic [ADDR_W-1:0] cfg_base_addr, cfg_surface_stride, cfg_line_stride;
   logic              busy, done;
   int                n_chk = 0;
   int                n_bad = 0;

   elementwise_wb_agen_if #(.DAT_W(DAT_W), .ADDR_W(ADDR_W)) bus ();

   elementwise_wb_agen #(.DAT_W(DAT_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PIX_BYTES(64)) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .cfg_hout           (cfg_hout),
      .cfg_wout           (cfg_wout),
      .cfg_ch_div_tout    (cfg_ch_div_tout),
      .cfg_base_addr      (cfg_base_addr),
      .cfg_surface_stride (cfg_surface_stride),
      .cfg_line_stride    (cfg_line_stride),
      .busy               (busy),
      .done               (done),
      .bus                (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mk_data(int i);
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'h5A00_0000 + 32'(i*8 + k);
      return d;
   endfunction

   function automatic logic [31:0] exp_addr(logic [31:0] base, logic [31:0] ls, logic [31:0] ss,
                                            int w_n, int h_n, int idx);
      int w, h, c;
      w = idx % w_n;
      h = (idx / w_n) % h_n;
      c = idx / (w_n * h_n);
      return base + 32'(c) * ss + 32'(h) * ls + 32'(w) * 32'd64;
   endfunction

   task automatic check_idle_outputs(input string nm);
      chk({nm, "_busy"},  256'(busy), 256'(0));
      chk({nm, "_done"},  256'(done), 256'(0));
      chk({nm, "_srdy"},  256'(bus.s_ready), 256'(0));
      chk({nm, "_mval"},  256'(bus.m_valid), 256'(0));
      chk({nm, "_maddr"}, 256'(bus.m_addr), 256'(0));
      chk({nm, "_mdata"}, bus.m_data, 256'(0));
      chk({nm, "_mlast"}, 256'(bus.m_last), 256'(0));
   endtask

   // Drives one job from a negedge; samples 1ns before each posedge.
   task automatic run_job(input int h_n, input int w_n, input int c_n,
                          input logic [31:0] base, input logic [31:0] ls, input logic [31:0] ss,
                          input int rdy_mode, input int bub_mode, input int restart_at,
                          input int abort_at, input bit spot, input string nm);
      int n, in_idx, out_idx, cyc, done_cyc, last_cyc, first_cyc, dones;
      bit held, prev_acc, restarted;
      logic [31:0]  h_addr;
      logic [255:0] h_data;
      logic         h_last;
      int           spot_idx[5];
      logic [31:0]  spot_addr[5];
      spot_idx  = '{0, 63, 64, 320, 639};
      spot_addr = '{32'h0800_0000, 32'h0800_0FC0, 32'h0800_1000, 32'h0800_5000, 32'h0800_9FC0};
      n = h_n * w_n * c_n;
      in_idx = 0; out_idx = 0; cyc = 0; dones = 0;
      done_cyc = -1; last_cyc = -1; first_cyc = -1;
      held = 0; prev_acc = 0; restarted = 0;
      h_addr = '0; h_data = '0; h_last = 1'b0;

      @(negedge clk);
      cfg_hout = CNT_W'(h_n); cfg_wout = CNT_W'(w_n); cfg_ch_div_tout = CNT_W'(c_n);
      cfg_base_addr = base; cfg_line_stride = ls; cfg_surface_stride = ss;
      start = 1'b1;
      bus.s_valid = 1'b0; bus.m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_run_busy"}, 256'(busy), 256'(1));
      chk({nm, "_run_srdy"}, 256'(bus.s_ready), 256'(1));

      while (cyc < 4000) begin
         if (abort_at >= 0 && out_idx >= abort_at) break;
         if (done) begin dones++; done_cyc = cyc; break; end
         start = 1'b0;
         if (restart_at >= 0 && out_idx == restart_at && !restarted) begin
            start = 1'b1; restarted = 1; cfg_wout = CNT_W'(1); cfg_base_addr = 32'h0;
         end
         bus.m_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.s_valid = (bub_mode != 0) ? (cyc % 2 == 0) : 1'b1;
         bus.s_data  = mk_data(in_idx);
         #4;
         if (rdy_mode == 0) chk({nm, "_mv_follow"}, 256'(bus.m_valid), 256'(prev_acc));
         if (held) begin
            chk({nm, "_hold_v"},    256'(bus.m_valid), 256'(1));
            chk({nm, "_hold_addr"}, 256'(bus.m_addr), 256'(h_addr));
            chk({nm, "_hold_data"}, bus.m_data, h_data);
            chk({nm, "_hold_last"}, 256'(bus.m_last), 256'(h_last));
         end
         held = 0;
         if (bus.m_valid) begin
            if (bus.m_ready) begin
               chk({nm, "_addr"}, 256'(bus.m_addr), 256'(exp_addr(base, ls, ss, w_n, h_n, out_idx)));
               chk({nm, "_data"}, bus.m_data, mk_data(out_idx));
               chk({nm, "_last"}, 256'(bus.m_last), 256'(out_idx == n - 1));
               if (spot)
                  for (int k = 0; k < 5; k++)
                     if (out_idx == spot_idx[k]) chk({nm, "_spot"}, 256'(bus.m_addr), 256'(spot_addr[k]));
               if (out_idx == 0) first_cyc = cyc;
               last_cyc = cyc;
               out_idx++;
            end else begin
               held = 1; h_addr = bus.m_addr; h_data = bus.m_data; h_last = bus.m_last;
            end
         end
         prev_acc = bus.s_valid && bus.s_ready;
         if (prev_acc) in_idx++;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      bus.s_valid = 1'b0;
      if (abort_at < 0) begin
         chk({nm, "_done_seen"}, 256'(dones), 256'(1));
         chk({nm, "_beats_out"}, 256'(out_idx), 256'(n));
         chk({nm, "_beats_in"},  256'(in_idx), 256'(n));
         chk({nm, "_done_lat"},  256'(done_cyc - last_cyc), 256'(1));
         if (rdy_mode == 0 && bub_mode == 0)
            chk({nm, "_b2b_span"}, 256'(last_cyc - first_cyc), 256'(n - 1));
         @(negedge clk);
         chk({nm, "_done_pulse"}, 256'(done), 256'(0));
         chk({nm, "_busy_fall"},  256'(busy), 256'(0));
         repeat (3) @(negedge clk);
         chk({nm, "_stay_idle"},  256'(busy), 256'(0));
         chk({nm, "_no_mval"},    256'(bus.m_valid), 256'(0));
      end else begin
         chk({nm, "_abort_point"}, 256'(out_idx), 256'(abort_at));
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0;
      cfg_hout = '0; cfg_wout = '0; cfg_ch_div_tout = '0;
      cfg_base_addr = '0; cfg_surface_stride = '0; cfg_line_stride = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      run_job(5, 64, 2, 32'h0800_0000, 32'h1000, 32'h5000, 0, 0, -1, -1, 1'b1, "nom");
      run_job(5, 64, 2, 32'h0800_0000, 32'h1000, 32'h5000, 1, 0, -1, -1, 1'b1, "bp");
      run_job(5, 64, 2, 32'h0800_0000, 32'h1000, 32'h5000, 0, 1, -1, -1, 1'b1, "bub");

      // zero-dimension job
      @(negedge clk);
      cfg_hout = 16'd5; cfg_wout = 16'd0; cfg_ch_div_tout = 16'd2;
      start = 1'b1; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zd_done_t1", 256'(done), 256'(1));
      chk("zd_busy_t1", 256'(busy), 256'(1));
      chk("zd_srdy_t1", 256'(bus.s_ready), 256'(0));
      chk("zd_mval_t1", 256'(bus.m_valid), 256'(0));
      @(negedge clk);
      chk("zd_done_t2", 256'(done), 256'(0));
      chk("zd_busy_t2", 256'(busy), 256'(0));
      chk("zd_mval_t2", 256'(bus.m_valid), 256'(0));
      bus.s_valid = 1'b0;

      run_job(5, 64, 2, 32'h0800_0000, 32'h1000, 32'h5000, 0, 0, 100, -1, 1'b1, "restart");

      run_job(5, 64, 2, 32'h0800_0000, 32'h1000, 32'h5000, 0, 0, -1, 200, 1'b1, "abort");
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      repeat (2) @(negedge clk);
      chk("midrst_no_done", 256'(done), 256'(0));
      chk("midrst_no_busy", 256'(busy), 256'(0));
      rst = 1'b0;

      run_job(1, 4, 1, 32'h1000_0000, 32'h1000, 32'h5000, 0, 0, -1, -1, 1'b0, "small");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
